// File: rtl/uart_pkg.sv
// Shared UART definitions: baud encoding, transmitter states and the bit-period divisor.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    BAUD24  = 2'b00,
    BAUD48  = 2'b01,
    BAUD96  = 2'b10,
    BAUD192 = 2'b11
  } baud_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Clock cycles per bit, truncated; unrecognised codes fall back to 9600.
  function automatic int unsigned bit_div(input baud_e baud, input int unsigned clk_hz);
    int unsigned rate;
    case (baud)
      BAUD24:  rate = 2400;
      BAUD48:  rate = 4800;
      BAUD96:  rate = 9600;
      BAUD192: rate = 19200;
      default: rate = 9600;
    endcase
    return clk_hz / rate;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period counter: holds the divisor latched at accept and flags the last cycle of each bit.
module uart_tx_bit_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             bit_end_c
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign bit_end_c = en_i && (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = bit_end_c ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load_i) begin
        div_q <= div_i;
      end
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DIV_W       = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] baud_rate,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       stop2,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  tx_state_e        state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             stop2_q, stop2_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_c;
  logic             bit_end_c;
  logic [DIV_W-1:0] div_sel_c;

  assign div_sel_c = DIV_W'(bit_div(baud_e'(baud_rate), CLK_FREQ_HZ));

  uart_tx_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_i    (load_c),
    .en_i      (busy_q),
    .div_i     (div_sel_c),
    .bit_end_c (bit_end_c)
  );

  // Next-state and next-output logic; each transition loads the level for the coming bit.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    load_c     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          load_c     = 1'b1;
          shreg_d    = tx_data;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          par_en_d   = parity_en;
          par_bit_d  = parity_odd ? ~^tx_data : ^tx_data;
          stop2_d    = stop2;
          state_d    = START;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (bit_end_c) begin
          state_d   = DATA;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = STOP;
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end_c) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end_c) begin
          tx_d = 1'b1;
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule
